// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 (CPU MEM stage) wins by default. Port 1 wins a contended cycle
// once port 0 has taken MAX_HOLD contended grants in a row.
// Illegal accesses are granted so the requester is released, but they never
// reach the memory. Each one produces a one-cycle error pulse.
module dm_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_stall,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  output logic        dm_re,
  input  logic [31:0] dm_dout
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt;
  logic             sel1;
  logic             sel_we;
  logic             illegal;
  logic             any_gnt;

  // Pick the winner and steer the selected port onto the memory bus.
  // The port 0 address is the idle default.
  always_comb begin
    sel1     = m1_req & (~m0_req | (hold_cnt == HOLD_LIMIT));
    m0_gnt   = reset & m0_req & ~sel1;
    m1_gnt   = reset & sel1;
    m0_stall = m0_req & ~m0_gnt;
    any_gnt  = m0_gnt | m1_gnt;
    dm_addr  = sel1 ? m1_addr  : m0_addr;
    dm_din   = sel1 ? m1_wdata : m0_wdata;
    sel_we   = sel1 ? m1_we    : m0_we;
    illegal  = (dm_addr[1:0] != 2'b00) || (dm_addr[31:12] != 20'd0);
    dm_we    = any_gnt & ~illegal & sel_we;
    dm_re    = any_gnt & ~illegal & ~sel_we;
  end

  // Count consecutive contended wins by port 0.
  // Any cycle without contention, or a port 1 win, clears the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (m0_req && m1_req && m0_gnt) begin
      if (hold_cnt != HOLD_LIMIT) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Port 0 response: one-cycle read-valid or error pulse after each grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~illegal & ~m0_we;
      m0_err    <= m0_gnt & illegal;
      if (m0_gnt && !illegal && !m0_we) m0_rdata <= dm_dout;
    end
  end

  // Port 1 response: one-cycle read-valid or error pulse after each grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m1_rvalid <= m1_gnt & ~illegal & ~m1_we;
      m1_err    <= m1_gnt & illegal;
      if (m1_gnt && !illegal && !m1_we) m1_rdata <= dm_dout;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter. A behavioural memory is attached to the bus.
// Each cycle's expected registered response is queued when the stimulus is
// driven, then popped and compared after the clock edge.
module tb_dm_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_stall, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dm_addr, dm_din, dm_dout;
  logic        dm_we, dm_re;

  logic [31:0] mem     [1024] = '{default: 32'd0};
  logic [31:0] ref_mem [1024] = '{default: 32'd0};

  typedef struct {
    logic        rv0, err0, rv1, err1;
    logic [31:0] rd0, rd1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rd0 = 32'd0;
  logic [31:0] exp_rd1 = 32'd0;
  int          compared = 0;
  int          mismatched = 0;
  int          hold = 0;

  dm_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_re(dm_re),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr[11:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
  endfunction

  // One clock cycle with the inputs already driven; eg0/eg1 are the expected grants.
  task automatic cycle(input bit eg0, input bit eg1);
    exp_t        e;
    logic [31:0] a, wd;
    logic        we, g, lg;
    @(negedge clk);
    chk("m0_gnt", m0_gnt, eg0);
    chk("m1_gnt", m1_gnt, eg1);
    chk("m0_stall", m0_stall, m0_req & ~eg0);
    a  = eg1 ? m1_addr  : m0_addr;
    wd = eg1 ? m1_wdata : m0_wdata;
    we = eg1 ? m1_we    : m0_we;
    g  = eg0 | eg1;
    lg = legal(a);
    chk("dm_we", dm_we, g & lg & we);
    chk("dm_re", dm_re, g & lg & ~we);
    if (g && lg) chk("dm_addr", dm_addr, a);
    if (g && lg && we) chk("dm_din", dm_din, wd);
    e.rv0 = 1'b0; e.err0 = 1'b0; e.rv1 = 1'b0; e.err1 = 1'b0;
    e.rd0 = exp_rd0; e.rd1 = exp_rd1;
    if (eg0) begin
      e.err0 = ~lg;
      if (lg && !we) begin e.rv0 = 1'b1; e.rd0 = ref_mem[a[11:2]]; end
    end
    if (eg1) begin
      e.err1 = ~lg;
      if (lg && !we) begin e.rv1 = 1'b1; e.rd1 = ref_mem[a[11:2]]; end
    end
    exp_rd0 = e.rd0;
    exp_rd1 = e.rd1;
    if (g && lg && we) ref_mem[a[11:2]] = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("m0_rvalid", m0_rvalid, e.rv0);
    chk("m0_err", m0_err, e.err0);
    chk("m0_rdata", m0_rdata, e.rd0);
    chk("m1_rvalid", m1_rvalid, e.rv1);
    chk("m1_err", m1_err, e.err1);
    chk("m1_rdata", m1_rdata, e.rd1);
  endtask

  // Run n contended cycles; the grant model tracks the hold count.
  task automatic contend(input int n);
    bit w1;
    for (int i = 0; i < n; i++) begin
      w1 = (hold == MAX_HOLD);
      cycle(!w1, w1);
      hold = w1 ? 0 : hold + 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low with a pending CPU write
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;  m1_wdata = 32'h0;
    #2;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_dm_we", dm_we, 1'b0);
    chk("rst_dm_re", dm_re, 1'b0);
    m0_req = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_m0_rvalid", m0_rvalid, 1'b0);
    chk("rel_m0_err", m0_err, 1'b0);
    chk("rel_m1_rvalid", m1_rvalid, 1'b0);
    chk("rel_m1_err", m1_err, 1'b0);
    chk("rel_m0_rdata", m0_rdata, 32'd0);
    chk("rel_hold_cnt", 32'(dut.hold_cnt), 32'd0);

    // CPU write then read of the same word
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    cycle(1, 0);
    m0_we = 1'b0;
    cycle(1, 0);
    chk("m0_rd_deadbeef", m0_rdata, 32'hDEADBEEF);
    m0_req = 1'b0;
    cycle(0, 0);

    // Sustained contention: m0 x4, m1, m0 x4, m1, m0 x2
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    hold = 0;
    contend(12);
    m0_req = 1'b0; m1_req = 1'b0;
    cycle(0, 0);
    hold = 0;

    // Illegal port 1 accesses: misaligned read, out-of-range write
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1002;
    cycle(0, 1);
    m1_we = 1'b1; m1_addr = 32'h0000_1000; m1_wdata = 32'hFFFF_FFFF;
    cycle(0, 1);
    m1_req = 1'b0;
    cycle(0, 0);
    chk("mem_word0", mem[0], 32'd0);

    // Port 1 write followed immediately by a CPU read of the same word
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4; m1_wdata = 32'h1234_5678;
    cycle(0, 1);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    cycle(1, 0);
    chk("raw_m0_rdata", m0_rdata, 32'h1234_5678);
    m0_req = 1'b0;
    cycle(0, 0);

    // Build up a nonzero hold count, then reset while a read is in flight
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    hold = 0;
    contend(2);
    @(negedge clk);
    chk("pend_m0_gnt", m0_gnt, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid_m0_gnt", m0_gnt, 1'b0);
    chk("rstmid_m1_gnt", m1_gnt, 1'b0);
    @(posedge clk); #1;
    chk("rstmid_m0_rvalid", m0_rvalid, 1'b0);
    chk("rstmid_hold_cnt", 32'(dut.hold_cnt), 32'd0);
    exp_rd0 = 32'd0;
    exp_rd1 = 32'd0;
    #2 reset = 1'b1;
    hold = 0;
    contend(6);
    m0_req = 1'b0; m1_req = 1'b0;
    cycle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
